// File: rtl/alu_cmd_ctrl_if.sv
// rtl/alu_cmd_ctrl_if.sv - RX byte, ALU and TX-FIFO signal bundle for alu_cmd_ctrl
interface alu_cmd_ctrl_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int ALU_OUT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    RX_P_DATA;
    logic                     RX_D_VLD;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_VLD;
    logic                     FIFO_FULL;
    logic [DATA_WIDTH-1:0]    ALU_A;
    logic [DATA_WIDTH-1:0]    ALU_B;
    logic [ALU_FUN_WIDTH-1:0] ALU_FUN;
    logic                     ALU_EN;
    logic [DATA_WIDTH-1:0]    WR_DATA;
    logic                     WR_INC;
    logic                     BUSY;

    // master: the command controller; slave: the RX path, ALU and FIFO around it
    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN, WR_DATA, WR_INC, BUSY
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN, WR_DATA, WR_INC, BUSY
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - parses RX command frames, runs the ALU and pushes the result to the TX FIFO
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ALU_FUN_WIDTH = 4,
    parameter int                    ALU_OUT_WIDTH = 16,
    parameter int                    TIMEOUT       = 15,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP    = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP   = 8'hDD,
    parameter logic [DATA_WIDTH-1:0] ERR_BYTE      = 8'hEE
) (
    input  logic          CLK,
    input  logic          RST,
    alu_cmd_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, SEND_LO, SEND_HI, SEND_ERR
    } state_t;

    state_t                   state_q, state_nxt;
    logic [DATA_WIDTH-1:0]    alu_a_q, alu_a_nxt;
    logic [DATA_WIDTH-1:0]    alu_b_q, alu_b_nxt;
    logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_nxt;
    logic                     alu_en_q, alu_en_nxt;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_nxt;
    logic                     wr_inc_q, wr_inc_nxt;
    logic                     busy_q, busy_nxt;
    logic [ALU_OUT_WIDTH-1:0] result_q, result_nxt;
    logic [CNT_W-1:0]         cnt_q, cnt_nxt;
    logic [CNT_W-1:0]         cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_fun_q <= '0;
            alu_en_q  <= 1'b0;
            wr_data_q <= '0;
            wr_inc_q  <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_nxt;
            alu_a_q   <= alu_a_nxt;
            alu_b_q   <= alu_b_nxt;
            alu_fun_q <= alu_fun_nxt;
            alu_en_q  <= alu_en_nxt;
            wr_data_q <= wr_data_nxt;
            wr_inc_q  <= wr_inc_nxt;
            busy_q    <= busy_nxt;
            result_q  <= result_nxt;
            cnt_q     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        alu_a_nxt   = alu_a_q;
        alu_b_nxt   = alu_b_q;
        alu_fun_nxt = alu_fun_q;
        alu_en_nxt  = alu_en_q;
        wr_data_nxt = wr_data_q;
        wr_inc_nxt  = 1'b0;
        result_nxt  = result_q;
        cnt_nxt     = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == CMD_ALU_OP) begin
                        state_nxt = GET_A;
                    end else if (bus.RX_P_DATA == CMD_ALU_NOP) begin
                        state_nxt = GET_FUN;
                    end
                end
            end
            GET_A: begin
                if (bus.RX_D_VLD) begin
                    alu_a_nxt = bus.RX_P_DATA;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (bus.RX_D_VLD) begin
                    alu_b_nxt = bus.RX_P_DATA;
                    state_nxt = GET_FUN;
                end
            end
            GET_FUN: begin
                if (bus.RX_D_VLD) begin
                    alu_fun_nxt = bus.RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    alu_en_nxt  = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ALU_RUN;
                end
            end
            ALU_RUN: begin
                // a result arriving on the final wait cycle still beats the timeout
                if (bus.ALU_OUT_VLD) begin
                    result_nxt = bus.ALU_OUT;
                    alu_en_nxt = 1'b0;
                    state_nxt  = SEND_LO;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    cnt_nxt    = cnt_inc;
                    alu_en_nxt = 1'b0;
                    state_nxt  = SEND_ERR;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            SEND_LO: begin
                if (!bus.FIFO_FULL) begin
                    wr_data_nxt = result_q[DATA_WIDTH-1:0];
                    wr_inc_nxt  = 1'b1;
                    state_nxt   = SEND_HI;
                end
            end
            SEND_HI: begin
                if (!bus.FIFO_FULL) begin
                    wr_data_nxt = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    wr_inc_nxt  = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            SEND_ERR: begin
                if (!bus.FIFO_FULL) begin
                    wr_data_nxt = ERR_BYTE;
                    wr_inc_nxt  = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.ALU_A   = alu_a_q;
    assign bus.ALU_B   = alu_b_q;
    assign bus.ALU_FUN = alu_fun_q;
    assign bus.ALU_EN  = alu_en_q;
    assign bus.WR_DATA = wr_data_q;
    assign bus.WR_INC  = wr_inc_q;
    assign bus.BUSY    = busy_q;
endmodule
